// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: each port keeps the grant for up to its weight
// in acknowledged transfers, then the grant rotates to the next requester.
module arbiter_wrr #(
  parameter int PORTS             = 4,
  parameter int WEIGHT_WIDTH      = 4,
  parameter bit LSB_HIGH_PRIORITY = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORTS-1:0]                request,
  input  logic [PORTS-1:0]                acknowledge,
  input  logic [PORTS*WEIGHT_WIDTH-1:0]   weight,
  output logic [PORTS-1:0]                grant,
  output logic                            grant_valid,
  output logic [$clog2(PORTS)-1:0]        grant_encoded,
  output logic [WEIGHT_WIDTH-1:0]         credit
);

  localparam int IDX_W = $clog2(PORTS);
  localparam logic [IDX_W-1:0] PTR_RESET =
    LSB_HIGH_PRIORITY ? IDX_W'(PORTS - 1) : {IDX_W{1'b0}};
  localparam logic [WEIGHT_WIDTH-1:0] CREDIT_ONE = {{(WEIGHT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PORTS-1:0]        GRANT_ONE  = {{(PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t                  state_r;
  logic [PORTS-1:0]        grant_r;
  logic                    grant_valid_r;
  logic [IDX_W-1:0]        grant_encoded_r;
  logic [WEIGHT_WIDTH-1:0] credit_r;
  logic [IDX_W-1:0]        last_r;

  logic [WEIGHT_WIDTH-1:0] weight_s [PORTS];
  logic [IDX_W-1:0]        base_s;
  logic [IDX_W-1:0]        cand_s;
  logic [IDX_W-1:0]        winner_s;
  logic                    found_s;
  logic                    ack_g_s;
  logic                    req_g_s;
  logic                    keep_s;
  logic [WEIGHT_WIDTH-1:0] win_credit_s;

  // A zero weight field still buys one transfer.
  function automatic logic [WEIGHT_WIDTH-1:0] eff_weight(input logic [WEIGHT_WIDTH-1:0] field);
    return (field == {WEIGHT_WIDTH{1'b0}}) ? CREDIT_ONE : field;
  endfunction

  for (genvar i = 0; i < PORTS; i++) begin : g_weight
    assign weight_s[i] = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  // Rotation search starting one past the base; the base itself is tried last,
  // so the releasing port only wins again when nobody else is asking.
  always_comb begin
    base_s   = (state_r == GRANTED) ? grant_encoded_r : last_r;
    cand_s   = {IDX_W{1'b0}};
    winner_s = {IDX_W{1'b0}};
    found_s  = 1'b0;
    for (int k = PORTS; k >= 1; k--) begin
      if (LSB_HIGH_PRIORITY) begin
        cand_s = IDX_W'((int'(base_s) + k) % PORTS);
      end else begin
        cand_s = IDX_W'((int'(base_s) + PORTS - k) % PORTS);
      end
      if (request[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
    win_credit_s = eff_weight(weight_s[winner_s]);
  end

  // Acknowledge/request of the currently granted port only.
  always_comb begin
    ack_g_s = acknowledge[grant_encoded_r];
    req_g_s = request[grant_encoded_r];
    if (req_g_s && (credit_r > CREDIT_ONE)) begin
      keep_s = 1'b1;
    end else begin
      keep_s = 1'b0;
    end
  end

  // Grant FSM; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      grant_r         <= {PORTS{1'b0}};
      grant_valid_r   <= 1'b0;
      grant_encoded_r <= {IDX_W{1'b0}};
      credit_r        <= {WEIGHT_WIDTH{1'b0}};
      last_r          <= PTR_RESET;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r         <= GRANTED;
            grant_r         <= GRANT_ONE << winner_s;
            grant_valid_r   <= 1'b1;
            grant_encoded_r <= winner_s;
            credit_r        <= win_credit_s;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANTED: begin
          if (!ack_g_s) begin
            state_r <= GRANTED;
          end else if (keep_s) begin
            credit_r <= credit_r - CREDIT_ONE;
          end else begin
            last_r <= grant_encoded_r;
            if (found_s) begin
              grant_r         <= GRANT_ONE << winner_s;
              grant_encoded_r <= winner_s;
              credit_r        <= win_credit_s;
            end else begin
              state_r         <= IDLE;
              grant_r         <= {PORTS{1'b0}};
              grant_valid_r   <= 1'b0;
              grant_encoded_r <= {IDX_W{1'b0}};
              credit_r        <= {WEIGHT_WIDTH{1'b0}};
            end
          end
        end
        default: begin
          state_r         <= IDLE;
          grant_r         <= {PORTS{1'b0}};
          grant_valid_r   <= 1'b0;
          grant_encoded_r <= {IDX_W{1'b0}};
          credit_r        <= {WEIGHT_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign grant         = grant_r;
  assign grant_valid   = grant_valid_r;
  assign grant_encoded = grant_encoded_r;
  assign credit        = credit_r;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for arbiter_wrr: one LSB-priority instance for most scenarios,
// one MSB-priority instance for the downward rotation order.
module tb_arbiter_wrr;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [3:0]  request_a, acknowledge_a, request_b, acknowledge_b;
  logic [15:0] weight_a, weight_b;
  logic [3:0]  grant_a, grant_b;
  logic        grant_valid_a, grant_valid_b;
  logic [1:0]  grant_encoded_a, grant_encoded_b;
  logic [3:0]  credit_a, credit_b;

  int n_total = 0;
  int n_pass  = 0;

  arbiter_wrr #(.PORTS(4), .WEIGHT_WIDTH(4), .LSB_HIGH_PRIORITY(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .request(request_a), .acknowledge(acknowledge_a),
    .weight(weight_a), .grant(grant_a), .grant_valid(grant_valid_a),
    .grant_encoded(grant_encoded_a), .credit(credit_a)
  );

  arbiter_wrr #(.PORTS(4), .WEIGHT_WIDTH(4), .LSB_HIGH_PRIORITY(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .request(request_b), .acknowledge(acknowledge_b),
    .weight(weight_b), .grant(grant_b), .grant_valid(grant_valid_b),
    .grant_encoded(grant_encoded_b), .credit(credit_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_a(input string tag, input logic [3:0] eg, input logic ev,
                         input logic [1:0] ee, input logic [3:0] ec);
    check({tag, ".grant"}, 32'(grant_a), 32'(eg));
    check({tag, ".valid"}, 32'(grant_valid_a), 32'(ev));
    check({tag, ".enc"}, 32'(grant_encoded_a), 32'(ee));
    check({tag, ".credit"}, 32'(credit_a), 32'(ec));
  endtask

  task automatic check_b(input string tag, input logic [3:0] eg, input logic ev,
                         input logic [1:0] ee, input logic [3:0] ec);
    check({tag, ".grant"}, 32'(grant_b), 32'(eg));
    check({tag, ".valid"}, 32'(grant_valid_b), 32'(ev));
    check({tag, ".enc"}, 32'(grant_encoded_b), 32'(ee));
    check({tag, ".credit"}, 32'(credit_b), 32'(ec));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rot_port [11] = '{1, 1, 2, 2, 2, 3, 3, 3, 3, 0, 1};
  int rot_cred [11] = '{2, 1, 3, 2, 1, 4, 3, 2, 1, 1, 2};
  int msb_port [5]  = '{3, 2, 1, 0, 3};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    request_a = 4'b0000; acknowledge_a = 4'b0000;
    request_b = 4'b1111; acknowledge_b = 4'b1111;
    weight_a = {4'd4, 4'd3, 4'd2, 4'd1};
    weight_b = {4'd1, 4'd1, 4'd1, 4'd1};
    step(); step();
    check_a("reset_a", 4'b0000, 1'b0, 2'd0, 4'd0);
    check_b("reset_b", 4'b0000, 1'b0, 2'd0, 4'd0);

    // First grant, then asynchronous reset in the middle of a grant.
    rst_a = 1'b0; request_a = 4'b1111;
    step();
    check_a("first_grant", 4'b0001, 1'b1, 2'd0, 4'd1);
    #2 rst_a = 1'b1;
    #1;
    check_a("async_reset", 4'b0000, 1'b0, 2'd0, 4'd0);
    #1 rst_a = 1'b0;
    step();
    check_a("after_reset", 4'b0001, 1'b1, 2'd0, 4'd1);

    // Weighted rotation with all ports requesting and every ack line high.
    acknowledge_a = 4'b1111;
    for (int i = 0; i < 11; i++) begin
      step();
      check_a($sformatf("rot%0d", i), 4'b0001 << rot_port[i], 1'b1,
              2'(rot_port[i]), 4'(rot_cred[i]));
    end

    // Blocking on ack: port 2 holds despite dropping its request.
    request_a = 4'b0100; acknowledge_a = 4'b0010;
    step();
    check_a("grant_p2", 4'b0100, 1'b1, 2'd2, 4'd3);
    request_a = 4'b1000; acknowledge_a = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      check_a($sformatf("hold%0d", i), 4'b0100, 1'b1, 2'd2, 4'd3);
    end
    acknowledge_a = 4'b0100;
    step();
    check_a("release_p2", 4'b1000, 1'b1, 2'd3, 4'd4);

    // Early release of port 1 at credit 3.
    weight_a = {4'd4, 4'd3, 4'd5, 4'd1};
    request_a = 4'b0010; acknowledge_a = 4'b1000;
    step();
    check_a("grant_p1", 4'b0010, 1'b1, 2'd1, 4'd5);
    request_a = 4'b1010; acknowledge_a = 4'b0010;
    step();
    check_a("p1_c4", 4'b0010, 1'b1, 2'd1, 4'd4);
    step();
    check_a("p1_c3", 4'b0010, 1'b1, 2'd1, 4'd3);
    request_a = 4'b1000;
    step();
    check_a("early_rel", 4'b1000, 1'b1, 2'd3, 4'd4);

    // Zero weight, sole requester: back-to-back credit-1 grants.
    weight_a = {4'd4, 4'd3, 4'd5, 4'd0};
    request_a = 4'b0001; acknowledge_a = 4'b1000;
    step();
    check_a("zero_w", 4'b0001, 1'b1, 2'd0, 4'd1);
    acknowledge_a = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check_a($sformatf("sole%0d", i), 4'b0001, 1'b1, 2'd0, 4'd1);
    end

    // Release with nobody requesting returns to idle.
    request_a = 4'b0000;
    step();
    check_a("to_idle", 4'b0000, 1'b0, 2'd0, 4'd0);
    acknowledge_a = 4'b0000;
    step();
    check_a("stay_idle", 4'b0000, 1'b0, 2'd0, 4'd0);

    // MSB-priority instance rotates downward from port 3.
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_b($sformatf("msb%0d", i), 4'b0001 << msb_port[i], 1'b1,
              2'(msb_port[i]), 4'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arbiter_wrr.md
Name: arbiter_wrr

Overview:
Weighted round-robin arbiter for the MAC/DMA shared-resource paths. It is the successor to the plain priority/round-robin arbiter. Each port holds the grant for up to WEIGHT[i] acknowledged transfers before the grant rotates. Weights are runtime-programmable. The grant is registered, and it blocks on acknowledge. The block sits between the per-channel request sources and the shared mux or bus master.

Parameters:
PORTS, 4, number of requesters (>=2)
WEIGHT_WIDTH, 4, width of each per-port weight field
LSB_HIGH_PRIORITY, 1, 1: rotation searches upward from last winner+1 (port 0 wins from reset); 0: searches downward (port PORTS-1 wins from reset)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
request  input  PORTS  per-port request, level
acknowledge  input  PORTS  per-port transfer-complete strobe, one pulse per transfer
weight  input  PORTS*WEIGHT_WIDTH  per-port weight; field i is bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
grant  output  PORTS  one-hot grant, registered
grant_valid  output  1  grant is non-zero
grant_encoded  output  $clog2(PORTS)  index of granted port (0 when idle)
credit  output  WEIGHT_WIDTH  remaining transfers for the current grant (0 when idle)

Behaviour:
- Reset (async assert, sync-released by the system): grant=0, grant_valid=0, grant_encoded=0, credit=0, state=IDLE.
  - Last-winner pointer resets to PORTS-1 when LSB_HIGH_PRIORITY=1 and to 0 when LSB_HIGH_PRIORITY=0.
  - Reset mid-grant drops the grant immediately and discards the remaining credit.
- States: IDLE, GRANTED.
- IDLE:
  - If any request bit is set, the winner is the first requesting port in rotation order after the last winner, wrapping.
  - Next cycle: grant=onehot(winner), grant_valid=1, credit=eff_weight(winner), state=GRANTED.
  - Latency from request to grant is 1 cycle.
- eff_weight(i) = weight field i, but a field of 0 is treated as 1.
  - Weight is sampled only when a grant is issued; changes during a grant take effect at the next grant of that port.
- GRANTED, port g:
  - The grant is held while acknowledge[g]=0, regardless of request[g]. This is blocking on ack.
  - acknowledge bits of non-granted ports are ignored.
  - On acknowledge[g]=1 with credit>1 and request[g]=1 in the same cycle: keep g, credit<=credit-1.
  - On acknowledge[g]=1 with credit==1, or with request[g]=0: release g. The last-winner pointer becomes g.
  - Re-arbitration on release happens in the same cycle (no idle bubble). The winner is the first requester after g in rotation order. g itself is eligible only if it is the sole requester.
  - The new grant and the reloaded credit appear on the next cycle.
  - If no request is present at release: grant<=0, credit<=0, state=IDLE.
- Rotation is fair: with all ports requesting continuously, ports are served cyclically, each port for eff_weight transfers.
- credit arithmetic: unsigned WEIGHT_WIDTH, never below 1 while GRANTED, no wrap.
- grant_encoded and credit are always consistent with grant on the same cycle.

Test Plan:
- Reset/idle: rst pulse asynchronously mid-cycle with request=4'b1111, grant active -> outputs 0 immediately. After release, port 0 is granted 1 cycle later with credit=weight[0].
- Weighted rotation: PORTS=4, weights {1,2,3,4} (port0..3), request=4'b1111 constant, ack every cycle -> grant sequence 0,1,1,2,2,2,3,3,3,3,0,...; credit counts down 1;2,1;3,2,1;4,3,2,1.
- Blocking on ack: grant port 2, drop request[2] with no ack for 10 cycles -> grant stays 4'b0100. Ack on port 1 is ignored. The first ack on port 2 releases it, and the next requester is granted the following cycle.
- Early release: weight[1]=5, port 1 granted, ack with request[1]=0 at credit=3 -> released. Port 3 (requesting) is granted next cycle with credit=weight[3].
- Zero weight and sole requester: weight[0]=0, only request[0]=1, acks each cycle -> credit=1 each grant. Port 0 is re-granted back-to-back with no gap in grant_valid.
- MSB mode: LSB_HIGH_PRIORITY=0, request=4'b1111, all weights 1 -> grant order 3,2,1,0,3.
